muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide sequencer attached to the execute (C) stage. It accepts one M-extension operation at a time from C, holds the pipeline with a stall request while it iterates, and returns a single-cycle-valid result that the execute stage captures in place of its ALU result. It uses one shared shift/add-subtract datapath for all eight RV32M funct3 codes.

---
 rtl/muldiv_unit_pkg.sv | 33 +++
 rtl/muldiv_unit_if.sv | 24 ++
 rtl/muldiv_unit.sv | 159 +++++++++++++++
 tb/tb_muldiv_unit.sv | 134 +++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared RV32M definitions: funct3 codes, sequencer state encoding and operand signedness.
package rv_pkg;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StPrep = 3'd1,
      StRun  = 3'd2,
      StFix  = 3'd3,
      StDone = 3'd4
   } state_e;

   // Returns {a_signed, b_signed} for an RV32M funct3.
   function automatic logic [1:0] op_signs(input logic [2:0] f3);
      logic [1:0] s;
      s = 2'b00;
      unique case (f3)
         F3_MULH, F3_DIV, F3_REM: s = 2'b11;
         F3_MULHSU:               s = 2'b10;
         default:                 s = 2'b00;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Execute-stage <-> multiply/divide sequencer handshake.
interface muldiv_unit_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  StartC;
   logic [2:0]            Funct3C;
   logic [DATA_WIDTH-1:0] OpAC;
   logic [DATA_WIDTH-1:0] OpBC;
   logic                  FlushH;
   logic                  StallH;
   logic                  BusyM;
   logic                  ValidM;
   logic [DATA_WIDTH-1:0] ResultM;

   modport master (
      output StartC, Funct3C, OpAC, OpBC, FlushH,
      input  StallH, BusyM, ValidM, ResultM
   );

   modport slave (
      input  StartC, Funct3C, OpAC, OpBC, FlushH,
      output StallH, BusyM, ValidM, ResultM
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M sequencer: one shared shift/add-subtract datapath, one bit per cycle,
// stalling the execute stage until a single-cycle-valid result is returned.
module muldiv_unit
   import rv_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input logic           clk,
   input logic           rst_n,
   muldiv_unit_if.slave  bus
);

   localparam int unsigned CntW = $clog2(DATA_WIDTH);
   localparam logic [CntW-1:0] CntLast = CntW'(DATA_WIDTH - 1);
   localparam logic [DATA_WIDTH-1:0] MinNeg = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   state_e                    state_q, state_d;
   logic [DATA_WIDTH-1:0]     op_a_q, op_a_d, op_b_q, op_b_d;
   logic [2:0]                f3_q, f3_d;
   logic [2*DATA_WIDTH-1:0]   acc_q, acc_d;
   logic [CntW-1:0]           cnt_q, cnt_d;
   logic                      sign_a_q, sign_a_d, sign_b_q, sign_b_d;
   logic [DATA_WIDTH-1:0]     result_q, result_d;
   logic                      valid_q, valid_d, busy_q, busy_d;

   logic [1:0]                sgn;
   logic                      sa, sb, is_div, is_rem;
   logic [DATA_WIDTH-1:0]     mag_a, mag_b;
   logic [DATA_WIDTH:0]       mul_sum, rem_sh, div_diff;
   logic                      div_ge;
   logic [DATA_WIDTH-1:0]     div_hi, quo, rem;
   logic [2*DATA_WIDTH-1:0]   prod;

   assign sgn    = op_signs(f3_q);
   assign sa     = sgn[1] & op_a_q[DATA_WIDTH-1];
   assign sb     = sgn[0] & op_b_q[DATA_WIDTH-1];
   assign mag_a  = sa ? -op_a_q : op_a_q;
   assign mag_b  = sb ? -op_b_q : op_b_q;
   assign is_div = f3_q[2];
   assign is_rem = f3_q[1];

   // Multiply: add multiplicand into the upper half when the current LSB is set, then shift right.
   assign mul_sum = {1'b0, acc_q[2*DATA_WIDTH-1:DATA_WIDTH]}
                  + (acc_q[0] ? {1'b0, op_b_q} : {(DATA_WIDTH+1){1'b0}});

   // Restoring divide: partial remainder keeps the bit shifted out of the upper half.
   assign rem_sh   = acc_q[2*DATA_WIDTH-1:DATA_WIDTH-1];
   assign div_ge   = rem_sh >= {1'b0, op_b_q};
   assign div_diff = rem_sh - {1'b0, op_b_q};
   assign div_hi   = div_ge ? div_diff[DATA_WIDTH-1:0] : rem_sh[DATA_WIDTH-1:0];

   assign prod = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
   assign quo  = (sign_a_q ^ sign_b_q) ? -acc_q[DATA_WIDTH-1:0] : acc_q[DATA_WIDTH-1:0];
   assign rem  = sign_a_q ? -acc_q[2*DATA_WIDTH-1:DATA_WIDTH] : acc_q[2*DATA_WIDTH-1:DATA_WIDTH];

   always_comb begin
      state_d  = state_q;
      op_a_d   = op_a_q;
      op_b_d   = op_b_q;
      f3_d     = f3_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      result_d = result_q;
      valid_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.StartC) begin
               op_a_d  = bus.OpAC;
               op_b_d  = bus.OpBC;
               f3_d    = bus.Funct3C;
               state_d = StPrep;
            end
         end
         StPrep: begin
            sign_a_d = sa;
            sign_b_d = sb;
            op_b_d   = mag_b;
            acc_d    = {{DATA_WIDTH{1'b0}}, mag_a};
            cnt_d    = '0;
            if (is_div && (op_b_q == '0)) begin
               result_d = is_rem ? op_a_q : '1;
               valid_d  = 1'b1;
               state_d  = StDone;
            end else if (is_div && !f3_q[0] && (op_a_q == MinNeg) && (op_b_q == '1)) begin
               result_d = is_rem ? '0 : MinNeg;
               valid_d  = 1'b1;
               state_d  = StDone;
            end else begin
               state_d  = StRun;
            end
         end
         StRun: begin
            cnt_d = cnt_q + 1'b1;
            acc_d = is_div ? {div_hi, acc_q[DATA_WIDTH-2:0], div_ge}
                           : {mul_sum, acc_q[DATA_WIDTH-1:1]};
            if (cnt_q == CntLast) state_d = StFix;
         end
         StFix: begin
            case (f3_q)
               F3_MUL:                        result_d = prod[DATA_WIDTH-1:0];
               F3_MULH, F3_MULHSU, F3_MULHU:  result_d = prod[2*DATA_WIDTH-1:DATA_WIDTH];
               F3_DIV, F3_DIVU:               result_d = quo;
               default:                       result_d = rem;
            endcase
            valid_d = 1'b1;
            state_d = StDone;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      // A kill abandons the op without touching the last result.
      if (bus.FlushH) begin
         state_d  = StIdle;
         valid_d  = 1'b0;
         result_d = result_q;
      end
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         op_a_q   <= '0;
         op_b_q   <= '0;
         f3_q     <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         result_q <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_a_q   <= op_a_d;
         op_b_q   <= op_b_d;
         f3_q     <= f3_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         result_q <= result_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.StallH  = rst_n & ~bus.FlushH
                      & (((state_q == StIdle) & bus.StartC) | (state_q == StPrep)
                         | (state_q == StRun) | (state_q == StFix));
   assign bus.BusyM   = busy_q;
   assign bus.ValidM  = valid_q;
   assign bus.ResultM = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, stall window, results, specials, flush, reset, hold.
module tb_muldiv_unit;
   import rv_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_pass = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   muldiv_unit_if #(.DATA_WIDTH(32)) bus ();

   muldiv_unit #(.DATA_WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Issue one op; lat is the cycle (relative to acceptance cycle t) in which ValidM must rise.
   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat,
                         input bit hold);
      int          vcyc;
      logic [31:0] res;
      bit          stall_ok, busy_ok;
      @(posedge clk); #1;
      bus.StartC = 1'b1; bus.Funct3C = f3; bus.OpAC = a; bus.OpBC = b;
      @(negedge clk);
      check({tag, " stall_t"}, 64'(bus.StallH), 64'd1);
      @(posedge clk); #1;
      if (!hold) bus.StartC = 1'b0;
      bus.OpAC = ~a; bus.OpBC = ~b;
      vcyc = 0; res = '0; stall_ok = 1'b1; busy_ok = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (bus.BusyM !== 1'b1) busy_ok = 1'b0;
         if (bus.StallH !== (k < lat)) stall_ok = 1'b0;
         if (bus.ValidM === 1'b1) begin
            vcyc = k;
            res  = bus.ResultM;
            break;
         end
      end
      check({tag, " valid_cycle"}, 64'(vcyc), 64'(lat));
      check({tag, " result"}, 64'(res), 64'(exp));
      check({tag, " stall_window"}, 64'(stall_ok), 64'd1);
      check({tag, " busy_window"}, 64'(busy_ok), 64'd1);
      @(posedge clk); #1;
      bus.StartC = 1'b0;
      @(negedge clk);
      check({tag, " single_pulse"}, 64'({bus.ValidM, bus.BusyM}), 64'd0);
   endtask

   initial begin
      bit vseen;
      bus.StartC = 1'b1; bus.Funct3C = '0; bus.OpAC = '0; bus.OpBC = '0; bus.FlushH = 1'b0;
      #12;
      check("reset ResultM", 64'(bus.ResultM), 64'd0);
      check("reset ValidM", 64'(bus.ValidM), 64'd0);
      check("reset BusyM", 64'(bus.BusyM), 64'd0);
      check("reset StallH", 64'(bus.StallH), 64'd0);
      bus.StartC = 1'b0;
      #3 rst_n = 1'b1;

      run_op("mul_7_m3",   F3_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 35, 1'b0);
      run_op("mulhu_m1",   F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35, 1'b0);
      run_op("mulh_m1",    F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 35, 1'b0);
      run_op("mulhsu_m1",  F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35, 1'b0);
      run_op("mul_m1",     F3_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 35, 1'b0);
      run_op("div_m7_2",   F3_DIV,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 35, 1'b0);
      run_op("rem_m7_2",   F3_REM,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 35, 1'b0);
      run_op("divu_100_7", F3_DIVU,   32'd100,      32'd7,        32'd14,        35, 1'b0);
      run_op("remu_100_7", F3_REMU,   32'd100,      32'd7,        32'd2,         35, 1'b0);
      run_op("div_by0",    F3_DIV,    32'd5,        32'd0,        32'hFFFF_FFFF, 2,  1'b0);
      run_op("rem_by0",    F3_REM,    32'd5,        32'd0,        32'd5,         2,  1'b0);
      run_op("div_ovf",    F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 1'b0);
      run_op("rem_ovf",    F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2, 1'b0);

      // Flush in RUN at t+10.
      @(posedge clk); #1;
      bus.StartC = 1'b1; bus.Funct3C = F3_MUL; bus.OpAC = 32'd5; bus.OpBC = 32'd6;
      @(posedge clk); #1;
      bus.StartC = 1'b0;
      vseen = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         if (bus.ValidM === 1'b1) vseen = 1'b1;
         @(posedge clk); #1;
      end
      bus.FlushH = 1'b1;
      @(negedge clk);
      check("flush StallH", 64'(bus.StallH), 64'd0);
      @(posedge clk); #1;
      bus.FlushH = 1'b0;
      @(negedge clk);
      check("flush idle BusyM", 64'(bus.BusyM), 64'd0);
      if (bus.ValidM === 1'b1) vseen = 1'b1;
      check("flush no ValidM", 64'(vseen), 64'd0);
      check("flush ResultM kept", 64'(bus.ResultM), 64'd0);
      run_op("mul_3_4", F3_MUL, 32'd3, 32'd4, 32'd12, 35, 1'b0);

      // Asynchronous reset mid-operation at t+20.
      @(posedge clk); #1;
      bus.StartC = 1'b1; bus.Funct3C = F3_MUL; bus.OpAC = 32'd9; bus.OpBC = 32'd9;
      @(posedge clk); #1;
      bus.StartC = 1'b0;
      repeat (19) @(posedge clk);
      #2;
      bus.StartC = 1'b1;
      rst_n = 1'b0;
      #1;
      check("arst ResultM", 64'(bus.ResultM), 64'd0);
      check("arst ValidM", 64'(bus.ValidM), 64'd0);
      check("arst BusyM", 64'(bus.BusyM), 64'd0);
      check("arst StallH", 64'(bus.StallH), 64'd0);
      bus.StartC = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      run_op("hold_mul_2_3", F3_MUL, 32'd2, 32'd3, 32'd6, 35, 1'b1);
      run_op("b2b_divu", F3_DIVU, 32'd81, 32'd9, 32'd9, 35, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
